// File: rtl/data_ram_arbiter_pkg.sv
// rtl/data_ram_arbiter_pkg.sv - shared types and defaults for the data RAM arbiter
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RDAT = 2'd2
  } mon_state_t;

  localparam int ADR_W_DEFAULT      = 12;
  localparam int STARVE_MAX_DEFAULT = 15;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - CPU, monitor and RAM port bundle of the data RAM arbiter
interface data_ram_arbiter_if
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEFAULT
);

  logic             cpu_re;
  logic [ADR_W-1:0] cpu_radr;
  logic [31:0]      cpu_rdata;
  logic [3:0]       cpu_we;
  logic [ADR_W-1:0] cpu_wadr;
  logic [31:0]      cpu_wdata;
  logic             cpu_stall;

  logic             mon_req;
  logic             mon_wr;
  logic [ADR_W-1:0] mon_adr;
  logic [31:0]      mon_wdata;
  logic [3:0]       mon_be;
  logic             mon_ack;
  logic             mon_rvalid;
  logic [31:0]      mon_rdata;

  logic [ADR_W-1:0] ram_radr;
  logic [31:0]      ram_rdata;
  logic [ADR_W-1:0] ram_wadr;
  logic [31:0]      ram_wdata;
  logic [3:0]       ram_wen;

  modport slave (
    input  cpu_re, cpu_radr, cpu_we, cpu_wadr, cpu_wdata,
    input  mon_req, mon_wr, mon_adr, mon_wdata, mon_be,
    input  ram_rdata,
    output cpu_rdata, cpu_stall,
    output mon_ack, mon_rvalid, mon_rdata,
    output ram_radr, ram_wadr, ram_wdata, ram_wen
  );

  modport master (
    output cpu_re, cpu_radr, cpu_we, cpu_wadr, cpu_wdata,
    output mon_req, mon_wr, mon_adr, mon_wdata, mon_be,
    output ram_rdata,
    input  cpu_rdata, cpu_stall,
    input  mon_ack, mon_rvalid, mon_rdata,
    input  ram_radr, ram_wadr, ram_wdata, ram_wen
  );

endinterface

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - shares the data RAM ports between the CPU MA stage and the debug monitor
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADR_W      = ADR_W_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  data_ram_arbiter_if.slave bus
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mon_state_t       state;
  mon_state_t       next_state;
  logic [CNT_W-1:0] starve_cnt;

  logic             cmd_wr;
  logic [ADR_W-1:0] cmd_adr;
  logic [31:0]      cmd_wdata;
  logic [3:0]       cmd_be;

  logic port_busy;
  logic issue;
  logic stall;
  logic mon_rd_issue;
  logic mon_wr_issue;
  logic rdat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      cmd_wr     <= 1'b0;
      cmd_adr    <= '0;
      cmd_wdata  <= '0;
      cmd_be     <= '0;
    end else begin
      state <= next_state;
      if (state == PEND && !issue) begin
        if (starve_cnt != CNT_MAX) begin
          starve_cnt <= starve_cnt + CNT_ONE;
        end
      end else begin
        starve_cnt <= '0;
      end
      if (state == IDLE && bus.mon_req) begin
        cmd_wr    <= bus.mon_wr;
        cmd_adr   <= bus.mon_adr;
        cmd_wdata <= bus.mon_wdata;
        cmd_be    <= bus.mon_be;
      end
    end
  end

  // A forced issue always lands on a port the CPU is using, so that is exactly the stall cycle.
  always_comb begin
    next_state   = state;
    port_busy    = cmd_wr ? (bus.cpu_we != 4'h0) : bus.cpu_re;
    issue        = !rst && (state == PEND) && (!port_busy || starve_cnt == CNT_MAX);
    stall        = issue && port_busy;
    mon_wr_issue = issue && cmd_wr;
    mon_rd_issue = issue && !cmd_wr;
    rdat         = !rst && (state == RDAT);
    case (state)
      IDLE: if (bus.mon_req) next_state = PEND;
      PEND: if (issue) next_state = cmd_wr ? IDLE : RDAT;
      RDAT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.ram_radr  = mon_rd_issue ? cmd_adr : bus.cpu_radr;
  assign bus.ram_wadr  = mon_wr_issue ? cmd_adr : bus.cpu_wadr;
  assign bus.ram_wdata = mon_wr_issue ? cmd_wdata : bus.cpu_wdata;
  assign bus.ram_wen   = rst          ? 4'h0 :
                         mon_wr_issue ? cmd_be :
                         stall        ? 4'h0 : bus.cpu_we;

  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.cpu_stall  = stall;
  assign bus.mon_ack    = mon_wr_issue || rdat;
  assign bus.mon_rvalid = rdat;
  assign bus.mon_rdata  = rdat ? bus.ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter with a cycle-level reference model
module tb_data_ram_arbiter;

  localparam int ADR_W      = 12;
  localparam int STARVE_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  always #5 clk = ~clk;

  data_ram_arbiter_if #(.ADR_W(ADR_W)) bus ();

  data_ram_arbiter #(.ADR_W(ADR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte-enabled RAM with a one-cycle registered read.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) mem[bus.ram_wadr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_radr];
  end

  // Reference model: a pending command issues on the first free-port cycle, or at the latest
  // STARVE_MAX+1 cycles after its request was sampled.
  logic [31:0] gold [0:4095];
  logic        m_busy = 1'b0;
  int          m_k = 0;
  logic        m_wr;
  logic [11:0] m_adr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_rd_due = 1'b0;
  logic [31:0] m_rd_data;
  logic        prev_rd = 1'b0;
  logic [31:0] exp_cpu;
  logic        last_stall = 1'b0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    logic        free, iss, stl, was_idle, acc_rd;
    logic [3:0]  e_wen;
    logic [11:0] e_wadr;
    logic [31:0] e_wdata;
    if (rst) begin
      if (mem_clr) for (int i = 0; i < 4096; i++) gold[i] = 32'h0;
      chk("rst mon_ack", 32'(bus.mon_ack), 32'h0);
      chk("rst mon_rvalid", 32'(bus.mon_rvalid), 32'h0);
      chk("rst mon_rdata", bus.mon_rdata, 32'h0);
      chk("rst cpu_stall", 32'(bus.cpu_stall), 32'h0);
      chk("rst ram_wen", 32'(bus.ram_wen), 32'h0);
      m_busy     = 1'b0;
      m_rd_due   = 1'b0;
      prev_rd    = 1'b0;
      last_stall = 1'b0;
    end else begin
      free    = m_wr ? (bus.cpu_we == 4'h0) : !bus.cpu_re;
      iss     = m_busy && (free || m_k == STARVE_MAX + 1);
      stl     = iss && !free;
      e_wen   = (iss && m_wr) ? m_be : (stl ? 4'h0 : bus.cpu_we);
      e_wadr  = (iss && m_wr) ? m_adr : bus.cpu_wadr;
      e_wdata = (iss && m_wr) ? m_wdata : bus.cpu_wdata;
      acc_rd  = bus.cpu_re && !stl;

      chk("cpu_stall", 32'(bus.cpu_stall), 32'(stl));
      chk("mon_ack", 32'(bus.mon_ack), 32'((iss && m_wr) || m_rd_due));
      chk("mon_rvalid", 32'(bus.mon_rvalid), 32'(m_rd_due));
      if (m_rd_due) chk("mon_rdata", bus.mon_rdata, m_rd_data);
      chk("ram_wen", 32'(bus.ram_wen), 32'(e_wen));
      if (e_wen != 4'h0) begin
        chk("ram_wadr", 32'(bus.ram_wadr), 32'(e_wadr));
        chk("ram_wdata", bus.ram_wdata, e_wdata);
      end
      if (iss && !m_wr) chk("ram_radr mon", 32'(bus.ram_radr), 32'(m_adr));
      else if (acc_rd) chk("ram_radr cpu", 32'(bus.ram_radr), 32'(bus.cpu_radr));
      if (prev_rd) chk("cpu_rdata", bus.cpu_rdata, exp_cpu);

      was_idle  = !m_busy && !m_rd_due;
      m_rd_data = gold[m_adr];
      exp_cpu   = gold[bus.cpu_radr];
      prev_rd   = acc_rd;
      for (int b = 0; b < 4; b++)
        if (e_wen[b]) gold[e_wadr][8*b +: 8] = e_wdata[8*b +: 8];
      m_rd_due = iss && !m_wr;
      if (iss) m_busy = 1'b0;
      else if (m_busy) m_k++;
      if (was_idle && bus.mon_req) begin
        m_busy  = 1'b1;
        m_k     = 1;
        m_wr    = bus.mon_wr;
        m_adr   = bus.mon_adr;
        m_wdata = bus.mon_wdata;
        m_be    = bus.mon_be;
      end
      last_stall = bus.cpu_stall;
      if (bus.cpu_stall) stall_cnt++;
    end
  end

  // CPU driver: 0 = direct values, 1 = back-to-back writes, 2 = read bursts with a gap every 4th cycle.
  int          mode = 0;
  int          widx = 0;
  int          ridx = 0;
  int          t = 0;
  logic        d_re;
  logic [11:0] d_radr;
  logic [3:0]  d_we;
  logic [11:0] d_wadr;
  logic [31:0] d_wdata;

  always begin
    @(posedge clk);
    #2;
    if (!last_stall) begin
      case (mode)
        1: begin
          if (bus.cpu_we != 4'h0) widx++;
          bus.cpu_re    = 1'b0;
          bus.cpu_we    = 4'hF;
          bus.cpu_wadr  = 12'(32'h100 + widx);
          bus.cpu_wdata = {16'hC0DE, 16'(widx)};
        end
        2: begin
          if (bus.cpu_re) ridx++;
          t++;
          bus.cpu_re   = (t % 4 != 3);
          bus.cpu_radr = 12'(32'h100 + (ridx % 16));
          bus.cpu_we   = 4'h0;
        end
        default: begin
          bus.cpu_re    = d_re;
          bus.cpu_radr  = d_radr;
          bus.cpu_we    = d_we;
          bus.cpu_wadr  = d_wadr;
          bus.cpu_wdata = d_wdata;
        end
      endcase
    end
  end

  task automatic mon_cmd(input logic wr, input logic [11:0] adr, input logic [31:0] data,
                         input logic [3:0] be, output int lat, output logic [31:0] rd,
                         output logic [3:0] a_wen, output logic a_stall, output logic a_rvalid);
    lat = -1; rd = 32'h0; a_wen = 4'h0; a_stall = 1'b0; a_rvalid = 1'b0;
    @(posedge clk); #1;
    bus.mon_req = 1'b1; bus.mon_wr = wr; bus.mon_adr = adr; bus.mon_wdata = data; bus.mon_be = be;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.mon_ack) begin
        lat = c; rd = bus.mon_rdata; a_wen = bus.ram_wen;
        a_stall = bus.cpu_stall; a_rvalid = bus.mon_rvalid;
        break;
      end
      @(posedge clk); #1;
      bus.mon_req = 1'b0;
    end
    bus.mon_req = 1'b0;
  endtask

  int          lat;
  int          s0;
  logic [31:0] rd;
  logic [3:0]  a_wen;
  logic        a_stall, a_rvalid;

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    bus.mon_req = 1'b0; bus.mon_wr = 1'b0; bus.mon_adr = '0; bus.mon_wdata = '0; bus.mon_be = '0;
    bus.cpu_re = 1'b0; bus.cpu_radr = '0; bus.cpu_we = '0; bus.cpu_wadr = '0; bus.cpu_wdata = '0;
    d_re = 1'b0; d_radr = '0; d_we = '0; d_wadr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; mem_clr = 1'b0;

    // Uncontended write then read-back.
    mon_cmd(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, lat, rd, a_wen, a_stall, a_rvalid);
    chk("wr latency", 32'(lat), 32'd1);
    chk("wr ram_wen", 32'(a_wen), 32'hF);
    mon_cmd(1'b0, 12'h010, 32'h0, 4'h0, lat, rd, a_wen, a_stall, a_rvalid);
    chk("rd latency", 32'(lat), 32'd2);
    chk("rd data", rd, 32'hDEADBEEF);
    chk("rd rvalid", 32'(a_rvalid), 32'h1);
    mon_cmd(1'b1, 12'h020, 32'hCAFEF00D, 4'hF, lat, rd, a_wen, a_stall, a_rvalid);
    mon_cmd(1'b1, 12'h040, 32'h55555555, 4'hF, lat, rd, a_wen, a_stall, a_rvalid);

    // Continuous CPU writes force the monitor write after STARVE_MAX blocked cycles.
    @(posedge clk); #1; mode = 1;
    repeat (3) @(posedge clk);
    s0 = stall_cnt;
    mon_cmd(1'b1, 12'h050, 32'h12345678, 4'hF, lat, rd, a_wen, a_stall, a_rvalid);
    chk("forced latency", 32'(lat), 32'(STARVE_MAX + 1));
    chk("forced stall", 32'(a_stall), 32'h1);
    chk("forced ram_wen", 32'(a_wen), 32'hF);
    @(negedge clk);
    chk("forced stall count", 32'(stall_cnt - s0), 32'd1);
    @(posedge clk); #1; mode = 0;

    // CPU read bursts: the monitor read slips into a gap without stalling.
    repeat (2) @(posedge clk);
    #1; mode = 2;
    repeat (3) @(posedge clk);
    s0 = stall_cnt;
    mon_cmd(1'b0, 12'h020, 32'h0, 4'h0, lat, rd, a_wen, a_stall, a_rvalid);
    chk("gap rd data", rd, 32'hCAFEF00D);
    chk("gap rd in time", 32'(lat >= 2 && lat <= 5), 32'h1);
    repeat (8) @(posedge clk);
    chk("gap no stall", 32'(stall_cnt - s0), 32'd0);
    #1; mode = 0;

    // Byte-lane write.
    mon_cmd(1'b1, 12'h030, 32'h11223344, 4'hF, lat, rd, a_wen, a_stall, a_rvalid);
    mon_cmd(1'b1, 12'h030, 32'h0000AB00, 4'b0010, lat, rd, a_wen, a_stall, a_rvalid);
    mon_cmd(1'b0, 12'h030, 32'h0, 4'h0, lat, rd, a_wen, a_stall, a_rvalid);
    chk("byte write", rd, 32'h1122AB44);

    // Reset while the monitor write is blocked.
    @(posedge clk); #1; mode = 1;
    repeat (2) @(posedge clk);
    #1; bus.mon_req = 1'b1; bus.mon_wr = 1'b1; bus.mon_adr = 12'h060;
    bus.mon_wdata = 32'hBADBAD00; bus.mon_be = 4'hF;
    @(posedge clk); #1; bus.mon_req = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("pend rst ack", 32'(bus.mon_ack), 32'h0);
    chk("pend rst stall", 32'(bus.cpu_stall), 32'h0);
    chk("pend rst wen", 32'(bus.ram_wen), 32'h0);
    @(posedge clk); #1; rst = 1'b0; mode = 0;
    @(negedge clk);
    chk("post rst ack", 32'(bus.mon_ack), 32'h0);
    chk("post rst stall", 32'(bus.cpu_stall), 32'h0);
    mon_cmd(1'b1, 12'h060, 32'h0F0F0F0F, 4'hF, lat, rd, a_wen, a_stall, a_rvalid);
    chk("post rst wr latency", 32'(lat), 32'd1);
    mon_cmd(1'b0, 12'h060, 32'h0, 4'h0, lat, rd, a_wen, a_stall, a_rvalid);
    chk("post rst rd", rd, 32'h0F0F0F0F);

    // Same-cycle CPU read and write of one word returns the old data.
    @(posedge clk); #1;
    d_re = 1'b1; d_radr = 12'h040; d_we = 4'hF; d_wadr = 12'h040; d_wdata = 32'h66666666;
    @(posedge clk); #1;
    d_we = 4'h0;
    @(negedge clk);
    chk("rw old data", bus.cpu_rdata, 32'h55555555);
    @(posedge clk); #1;
    d_re = 1'b0;
    @(negedge clk);
    chk("rw new data", bus.cpu_rdata, 32'h66666666);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares the single-read/single-write data RAM between the CPU MA stage and the UART debug monitor. The CPU has default priority on both RAM ports. Monitor accesses fill idle port slots, or take a slot by stalling the CPU after a bounded wait. The block sits between the MA-stage memory interface, the monitor command engine and the byte-enabled data RAM, which has a 1-cycle read latency.

## Interface
- ADR_W, 12, word address width of the RAM.
- STARVE_MAX, 15, number of blocked PEND cycles before the monitor forces a slot (≥1).

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_re  in  1  CPU read request this cycle
- cpu_radr  in  ADR_W  CPU read word address
- cpu_rdata  out  32  read data, valid the cycle after cpu_re is accepted
- cpu_we  in  4  CPU byte write enables
- cpu_wadr  in  ADR_W  CPU write word address
- cpu_wdata  in  32  CPU write data
- cpu_stall  out  1  CPU access refused this cycle; the CPU holds its request
- mon_req  in  1  monitor command request, sampled in IDLE
- mon_wr  in  1  1 = write, 0 = read
- mon_adr  in  ADR_W  monitor word address
- mon_wdata  in  32  monitor write data
- mon_be  in  4  monitor byte enables (write only)
- mon_ack  out  1  one-cycle completion pulse
- mon_rvalid  out  1  mon_rdata valid (coincides with mon_ack for reads)
- mon_rdata  out  32  monitor read data
- ram_radr  out  ADR_W  RAM read address
- ram_rdata  in  32  RAM read data (1-cycle latency)
- ram_wadr  out  ADR_W  RAM write address
- ram_wdata  out  32  RAM write data
- ram_wen  out  4  RAM byte write enables

## Operation
- Monitor FSM states:
  - IDLE: mon_req=1 latches mon_wr, mon_adr, mon_wdata and mon_be, then moves to PEND. Inputs are ignored outside IDLE.
  - PEND: the target port is the read port for reads and the write port for writes.
    - Port free (cpu_re=0 for a read, cpu_we=0 for a write), or starve counter == STARVE_MAX: issue the monitor access on that port.
    - Write issue: mon_ack=1 this cycle, next state IDLE.
    - Read issue: next state RDAT.
    - Otherwise: starve counter increments.
  - RDAT: mon_rvalid=1, mon_ack=1, mon_rdata=ram_rdata. Next state IDLE.
- Starve counter: width $clog2(STARVE_MAX+1), saturating. Cleared in every state other than PEND.
- Forced issue: cpu_stall=1 only in the cycle the monitor takes a port the CPU is requesting. The other port still serves the CPU's access that cycle unless stall holds the whole MA stage. Rule: when cpu_stall=1, neither CPU access is performed. ram_wen is driven by the monitor only on a monitor write, else 0.
- Port muxing is combinational:
  - ram_radr = monitor address when a monitor read is issued, else cpu_radr.
  - ram_wadr, ram_wdata, ram_wen = monitor values when a monitor write is issued, else CPU values. ram_wen = 0 when stalled.
- cpu_rdata = ram_rdata, passed straight through. A monitor read never coincides with an accepted CPU read, so there is no ambiguity.
- No forwarding: a same-cycle write and read to the same address returns the old data.
- Reset in any state: FSM to IDLE, counter to 0, latched command discarded. No ack is issued for a command cut off by reset.

## Timing
- Reset values: mon_ack=0, mon_rvalid=0, mon_rdata=0, cpu_stall=0, ram_wen=0.
- Monitor write latency (mon_req to mon_ack):
  - Uncontended: 2 cycles.
  - Worst case: STARVE_MAX+2 cycles.
- Monitor read latency: uncontended 3 cycles (IDLE→PEND→RDAT). Worst case STARVE_MAX+3 cycles.
- cpu_stall is at most 1 cycle per monitor command.
- mon_ack is one cycle wide. The next command can be sampled the cycle after ack.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, PEND=2'd1, RDAT=2'd2.
  - The default STARVE_MAX.
- Single module; no sub-module needed.

## Test plan
- Idle CPU, monitor write: adr 0x010, data 0xDEADBEEF, be 4'hF. Required: ram_wen=4'hF at cycle 1 after req, mon_ack at cycle 1. A later monitor read returns 0xDEADBEEF with mon_rvalid.
- CPU writes continuously, STARVE_MAX=15, monitor write pending. Required: exactly 15 blocked cycles, then 1 cycle of cpu_stall=1 with ram_wen from the monitor, mon_ack in the same cycle.
- CPU read bursts with one-cycle gaps, monitor read. Required: the monitor issues in the first gap with no cpu_stall. mon_rdata holds the monitor address's data, and cpu_rdata is correct on all CPU reads.
- Monitor byte write with be=4'b0010, data 0x0000AB00, over word 0x11223344. Required: readback is 0x1122AB44.
- Reset asserted in PEND under contention. Required: next cycle IDLE, no mon_ack, cpu_stall=0, ram_wen=0. A fresh command completes normally.
- CPU read and write to the same address in the same cycle. Required: old data is returned; the new data is visible on the next read.
